// File: rtl/bsg_cover_pkg.sv
// Shared types and helpers for the toggle-coverage producer/collector pair.
// ID encoding: id = base + 2*idx + dir, with dir in bit 0.
package bsg_cover_pkg;

  typedef enum logic {
    e_cover_fall = 1'b0,
    e_cover_rise = 1'b1
  } cover_dir_e;

  localparam int cover_cnt_width_lp = 32;

  function automatic int cover_id(
    input int         base,
    input int         idx,
    input cover_dir_e dir
  );
    return base + 2 * idx + int'(dir);
  endfunction

endpackage

// File: rtl/bsg_cover_toggle_rr_pick.sv
// Round-robin picker over a request vector with a grant-hold input.
// While held, the previously presented grant is kept stable.
module bsg_cover_toggle_rr_pick
  #(parameter int width_p = 2)
  (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [width_p-1:0]         req_i,
    input  logic                       hold_i,
    input  logic                       yumi_i,
    output logic                       v_o,
    output logic [$clog2(width_p)-1:0] idx_o,
    output logic [width_p-1:0]         one_hot_o
  );

  localparam int lg_lp = $clog2(width_p);

  logic [lg_lp-1:0] ptr_r;
  logic [lg_lp-1:0] lock_idx_r;
  logic             lock_v_r;
  logic [lg_lp-1:0] scan_idx;
  logic             scan_v;

  always_comb begin
    int j;
    scan_idx = '0;
    scan_v   = 1'b0;
    j        = 0;
    for (int k = 0; k < width_p; k++) begin
      j = int'(ptr_r) + k;
      if (j >= width_p) j = j - width_p;
      if (!scan_v && req_i[j]) begin
        scan_v   = 1'b1;
        scan_idx = lg_lp'(j);
      end
    end
  end

  assign v_o       = |req_i;
  assign idx_o     = lock_v_r ? lock_idx_r : scan_idx;
  assign one_hot_o = v_o ? (width_p'(1) << idx_o) : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r      <= '0;
      lock_v_r   <= 1'b0;
      lock_idx_r <= '0;
    end else begin
      if (yumi_i)
        ptr_r <= (idx_o == lg_lp'(width_p - 1)) ? '0 : idx_o + lg_lp'(1);
      lock_v_r   <= hold_i;
      lock_idx_r <= idx_o;
    end
  end

endmodule

// File: rtl/bsg_cover_toggle_encoder.sv
// Toggle-coverage producer: per-bit rise/fall events queued and emitted as IDs.
// BSG_COVER_TOGGLE_COALESCE_CNT_EN builds the saturating coalesced-event counter.
module bsg_cover_toggle_encoder
  import bsg_cover_pkg::*;
  #(parameter int num_signals_p = 16,
    parameter int width_p       = 10,
    parameter int id_base_p     = 0)
  (
    input  logic                          core_clk_i,
    input  logic                          core_reset_n_i,
    input  logic                          en_i,
    input  logic [num_signals_p-1:0]      signals_i,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          ready_i,
    output logic [cover_cnt_width_lp-1:0] coalesced_o
  );

  localparam int nb_lp = 2 * num_signals_p;
  localparam int lg_lp = $clog2(nb_lp);

  if (id_base_p % 2 != 0) begin : g_bad_base
    $error("id_base_p must be even");
  end
  if (longint'(id_base_p + nb_lp - 1) >= (longint'(1) << width_p)) begin : g_bad_width
    $error("width_p too small for id_base_p + 2*num_signals_p");
  end

  logic [num_signals_p-1:0] prev_r;
  logic                     primed_r;
  logic [nb_lp-1:0]         pending_r;
  logic [nb_lp-1:0]         set_vec;
  logic [nb_lp-1:0]         clr_vec;
  logic [nb_lp-1:0]         one_hot;
  logic [lg_lp-1:0]         pick_idx;
  logic                     pick_v;
  logic                     yumi;
  logic                     hold;

  always_comb begin
    set_vec = '0;
    if (en_i && primed_r) begin
      for (int i = 0; i < num_signals_p; i++) begin
        set_vec[2*i+1] =  signals_i[i] & ~prev_r[i];
        set_vec[2*i]   = ~signals_i[i] &  prev_r[i];
      end
    end
  end

  assign yumi    = pick_v & ready_i;
  assign hold    = pick_v & ~ready_i;
  assign clr_vec = yumi ? one_hot : '0;

  bsg_cover_toggle_rr_pick #(.width_p(nb_lp)) u_pick (
    .clk_i     (core_clk_i),
    .reset_n_i (core_reset_n_i),
    .req_i     (pending_r),
    .hold_i    (hold),
    .yumi_i    (yumi),
    .v_o       (pick_v),
    .idx_o     (pick_idx),
    .one_hot_o (one_hot)
  );

  assign v_o    = pick_v;
  assign data_o = pick_v
    ? width_p'(cover_id(id_base_p, int'(pick_idx) >> 1, cover_dir_e'(pick_idx[0])))
    : '0;

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      prev_r    <= '0;
      primed_r  <= 1'b0;
      pending_r <= '0;
    end else begin
      prev_r    <= signals_i;
      primed_r  <= 1'b1;
      pending_r <= (pending_r & ~clr_vec) | set_vec;
    end
  end

`ifdef BSG_COVER_TOGGLE_COALESCE_CNT_EN
  logic [nb_lp-1:0]              coal_hits;
  logic [cover_cnt_width_lp:0]   coal_sum;
  logic [cover_cnt_width_lp-1:0] coal_r;

  // a set landing on a bit that stays pending loses one event's multiplicity
  assign coal_hits = set_vec & pending_r & ~clr_vec;
  assign coal_sum  = {1'b0, coal_r} + (cover_cnt_width_lp + 1)'($countones(coal_hits));

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i)
      coal_r <= '0;
    else
      coal_r <= coal_sum[cover_cnt_width_lp] ? '1 : coal_sum[cover_cnt_width_lp-1:0];
  end

  assign coalesced_o = coal_r;
`else
  assign coalesced_o = '0;
`endif

endmodule

// File: tb/tb_bsg_cover_toggle_encoder.sv
// Bench for bsg_cover_toggle_encoder: event-queue model plus directed scenarios.
// Coalesced-count expectations follow BSG_COVER_TOGGLE_COALESCE_CNT_EN.
module tb_bsg_cover_toggle_encoder;

  localparam int N    = 4;
  localparam int W    = 10;
  localparam int BASE = 8;
  localparam int NB   = 2 * N;

`ifdef BSG_COVER_TOGGLE_COALESCE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b1;
  logic         ready = 1'b1;
  logic [N-1:0] sig   = '0;
  logic         v;
  logic [W-1:0] data;
  logic [31:0]  coal;

  int errors = 0;
  int checks = 0;
  int q[$];
  int e[$];

  bit [N-1:0] m_prev     = '0;
  bit         m_primed   = 1'b0;
  bit         m_pend[NB] = '{default: 1'b0};
  int         m_next     = 0;
  bit         m_lock     = 1'b0;
  int         m_lock_idx = 0;
  longint     m_coal     = 0;

  always #5 clk = ~clk;

  bsg_cover_toggle_encoder #(
    .num_signals_p (N),
    .width_p       (W),
    .id_base_p     (BASE)
  ) dut (
    .core_clk_i     (clk),
    .core_reset_n_i (rst_n),
    .en_i           (en),
    .signals_i      (sig),
    .v_o            (v),
    .data_o         (data),
    .ready_i        (ready),
    .coalesced_o    (coal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input int exp[$]);
    chk({name, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < q.size()) ? q[i] : -1, exp[i]);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // next event to be emitted: the held one, else first pending after the last served
  function automatic int pick();
    if (m_lock) return m_lock_idx;
    for (int k = 0; k < NB; k++)
      if (m_pend[(m_next + k) % NB]) return (m_next + k) % NB;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev   = '0;
      m_primed = 1'b0;
      m_next   = 0;
      m_lock   = 1'b0;
      m_coal   = 0;
      for (int j = 0; j < NB; j++) m_pend[j] = 1'b0;
    end else begin
      int s;
      bit hs;
      int nc;
      bit clr;
      bit setb[NB];
      s  = pick();
      hs = (s >= 0) && ready;
      nc = 0;
      for (int i = 0; i < N; i++) begin
        setb[2*i+1] = m_primed && en &&  sig[i] && !m_prev[i];
        setb[2*i]   = m_primed && en && !sig[i] &&  m_prev[i];
      end
      for (int j = 0; j < NB; j++) begin
        clr = hs && (j == s);
        if (setb[j] && m_pend[j] && !clr) nc++;
        m_pend[j] = setb[j] || (m_pend[j] && !clr);
      end
      m_coal = m_coal + nc;
      if (m_coal > 64'hFFFF_FFFF) m_coal = 64'hFFFF_FFFF;
      if (hs) m_next = (s + 1) % NB;
      m_lock     = (s >= 0) && !ready;
      m_lock_idx = s;
      m_prev     = sig;
      m_primed   = 1'b1;
    end
  end

  always @(negedge clk) begin
    int s;
    s = pick();
    chk("cyc_v", v, (s >= 0));
    chk("cyc_data", data, (s >= 0) ? BASE + s : 0);
    chk("cyc_coal", coal, CNT_EN ? m_coal[31:0] : 32'd0);
    if (v && ready) q.push_back(int'(data));
  end

  initial begin
    #3;
    chk("rst_v", v, 0);
    chk("rst_data", data, 0);
    chk("rst_coal", coal, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    q.delete();

    // single rise then fall, ready high
    sig = 4'b0001;
    step(1);
    chk("t1_v", v, 1);
    chk("t1_data", data, BASE + 1);
    step(3);
    e = {BASE + 1};
    chk_q("t1_rise", e);
    sig = 4'b0000;
    step(3);
    e = {BASE + 1, BASE + 0};
    chk_q("t1_fall", e);

    // primed gating right after reset
    rst_n = 1'b0;
    sig   = 4'b1111;
    step(1);
    rst_n = 1'b1;
    q.delete();
    step(5);
    chk("t2_count", q.size(), 0);
    chk("t2_v", v, 0);

    // backpressure hold then rr drain
    rst_n = 1'b0;
    sig   = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(2);
    ready = 1'b0;
    sig   = 4'b1101;
    step(1);
    chk("t3_v", v, 1);
    chk("t3_data", data, BASE + 1);
    step(3);
    chk("t3_hold", data, BASE + 1);
    q.delete();
    ready = 1'b1;
    step(3);
    e = {BASE + 1, BASE + 5, BASE + 7};
    chk_q("t3_drain", e);
    chk("t3_idle", v, 0);

    // coalescing on bit1
    ready = 1'b0;
    q.delete();
    sig = 4'b1111;
    step(1);
    sig = 4'b1101;
    step(1);
    sig = 4'b1111;
    step(1);
    chk("t4_coal", coal, CNT_EN ? 32'd1 : 32'd0);
    ready = 1'b1;
    step(3);
    e = {BASE + 3, BASE + 2};
    chk_q("t4_ids", e);
    chk("t4_idle", v, 0);

    // enable drop: earlier pending drains, new toggles ignored
    ready = 1'b0;
    sig   = 4'b1110;
    step(1);
    en  = 1'b0;
    sig = 4'b0001;
    step(1);
    sig = 4'b1110;
    step(1);
    q.delete();
    ready = 1'b1;
    step(3);
    e = {BASE + 0};
    chk_q("t5_ids", e);
    chk("t5_idle", v, 0);
    en = 1'b1;

    // async reset with pending events
    ready = 1'b0;
    sig   = 4'b1001;
    step(2);
    chk("t6_pend", v, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_v", v, 0);
    chk("t6_data", data, 0);
    chk("t6_coal", coal, 0);
    step(1);
    rst_n = 1'b1;
    q.delete();
    ready = 1'b1;
    step(5);
    chk("t6_count", q.size(), 0);
    chk("t6_idle", v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
